// File: rtl/vita_tx_async_msg_pkg.sv
// vita_tx_async_msg_pkg: state encodings, VITA header field constants and settings offsets for the async message path
package vita_tx_async_msg_pkg;
  typedef enum logic [2:0] {IDLE, HDR, SID, SECS, FRACH, FRACL, CODE} state_t;
  localparam logic [3:0] PKT_TYPE = 4'h5;
  localparam logic [1:0] TSI = 2'b11;
  localparam logic [1:0] TSF = 2'b01;
  localparam logic [15:0] PKT_LEN = 16'd6;
  localparam int SR_SID = 0;
  localparam int SR_CTRL = 1;
  localparam int SR_DROP_CLR = 2;
  function automatic logic [31:0] vita_hdr(input logic [3:0] seq);
    return {PKT_TYPE, 1'b0, 1'b0, 2'b00, TSI, TSF, seq, PKT_LEN};
  endfunction
endpackage

// File: rtl/vita_tx_async_msg_if.sv
// vita_tx_async_msg_if: 36-bit FIFO stream {occ, eop, sop, word} towards the host
interface vita_tx_async_msg_if;
  logic [35:0] data_o;
  logic src_rdy_o;
  logic dst_rdy_i;
  modport master(output data_o, src_rdy_o, input dst_rdy_i);
  modport slave(input data_o, src_rdy_o, output dst_rdy_i);
endinterface

// File: rtl/setting_reg.sv
// setting_reg: one settings-bus register at ADDR, with a one-cycle changed strobe after each write
module setting_reg #(
  parameter int ADDR = 0,
  parameter logic [31:0] AT_RESET = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic [7:0]  addr,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        changed
);
  logic hit;
  assign hit = strobe && addr == 8'(ADDR);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out <= AT_RESET;
      changed <= 1'b0;
    end else begin
      changed <= hit;
      if (hit) out <= in;
    end
endmodule

// File: rtl/vita_async_msg_queue.sv
// vita_async_msg_queue: synchronous FIFO of captured messages; push while full succeeds only alongside a pop
module vita_async_msg_queue #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH = 96
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full = count[DEPTH_LOG2];
  assign empty = count == '0;
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(do_wr);
      rp <= rp + DEPTH_LOG2'(do_rd);
      count <= count + (DEPTH_LOG2+1)'(do_wr) - (DEPTH_LOG2+1)'(do_rd);
    end
endmodule

// File: rtl/vita_tx_async_msg.sv
// vita_tx_async_msg: queues TX error/ack events and emits each as a 6-word VITA extension-context packet
// Define VITA_TX_ASYNC_DROP_CNT_EN for the overflow counter and loss flag in the CODE word.
module vita_tx_async_msg
  import vita_tx_async_msg_pkg::*;
#(
  parameter int BASE = 0,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         set_stb,
  input  logic [7:0]                   set_addr,
  input  logic [31:0]                  set_data,
  input  logic [63:0]                  vita_time,
  input  logic                         error,
  input  logic                         ack,
  input  logic [31:0]                  error_code,
  vita_tx_async_msg_if.master          tx,
  output logic [15:0]                  dropped_count,
  output logic [31:0]                  debug
);
  state_t state, state_nxt;
  logic [31:0] sid, ctrl, code_word;
  logic unused_sid_chg, unused_ctrl_chg, unused_ctrl;
  logic [95:0] q_dout, stage;
  logic q_full, q_empty, evt, xfer, pop;
  logic [QDEPTH_LOG2:0] q_count;
  logic [3:0] seqnum;
  setting_reg #(.ADDR(BASE + SR_SID)) sr_sid (
    .clk(clk), .reset_n(reset_n), .strobe(set_stb), .addr(set_addr), .in(set_data),
    .out(sid), .changed(unused_sid_chg)
  );
  setting_reg #(.ADDR(BASE + SR_CTRL)) sr_ctrl (
    .clk(clk), .reset_n(reset_n), .strobe(set_stb), .addr(set_addr), .in(set_data),
    .out(ctrl), .changed(unused_ctrl_chg)
  );
  assign unused_ctrl = ^ctrl[31:1];
  assign evt = ctrl[0] & (error | ack);
  assign tx.src_rdy_o = state != IDLE;
  assign xfer = tx.src_rdy_o & tx.dst_rdy_i;
  // the next message is pulled into staging whenever a packet may start
  assign pop = (state == IDLE || (state == CODE && xfer)) && !q_empty;
  vita_async_msg_queue #(.DEPTH_LOG2(QDEPTH_LOG2), .WIDTH(96)) queue (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr(evt), .din({error_code, vita_time}),
    .rd(pop), .dout(q_dout), .full(q_full), .empty(q_empty), .count(q_count)
  );
`ifdef VITA_TX_ASYNC_DROP_CNT_EN
  logic drop, drop_clr, drop_pending, code_loss;
  logic [31:0] unused_clr_val;
  setting_reg #(.ADDR(BASE + SR_DROP_CLR)) sr_drop_clr (
    .clk(clk), .reset_n(reset_n), .strobe(set_stb), .addr(set_addr), .in(set_data),
    .out(unused_clr_val), .changed(drop_clr)
  );
  assign drop = evt & q_full & ~pop;
  // loss flag is latched on entering CODE so the word stays stable under backpressure
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dropped_count <= '0;
      drop_pending <= 1'b0;
      code_loss <= 1'b0;
    end else if (clear) begin
      dropped_count <= '0;
      drop_pending <= 1'b0;
      code_loss <= 1'b0;
    end else begin
      if (drop_clr) dropped_count <= '0;
      else if (drop && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      if (state == FRACL && xfer) begin
        code_loss <= drop_pending | drop;
        drop_pending <= 1'b0;
      end else drop_pending <= drop_pending | drop;
    end
  assign code_word = {stage[95:80], stage[79] | code_loss, stage[78:64]};
`else
  assign dropped_count = 16'd0;
  assign code_word = stage[95:64];
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      seqnum <= '0;
      stage <= '0;
    end else if (clear) begin
      state <= IDLE;
      seqnum <= '0;
    end else begin
      state <= state_nxt;
      if (pop) stage <= q_dout;
      if (state == CODE && xfer) seqnum <= seqnum + 4'd1;
    end
  always_comb begin
    state_nxt = (state == IDLE || (state == CODE && xfer)) ? (q_empty ? IDLE : HDR) :
                xfer ? state_t'(state + 3'd1) : state;
    tx.data_o = '0;
    case (state)
      HDR:     tx.data_o = {4'b0001, vita_hdr(seqnum)};
      SID:     tx.data_o = {4'b0000, sid};
      SECS:    tx.data_o = {4'b0000, stage[63:32]};
      FRACL:   tx.data_o = {4'b0000, stage[31:0]};
      CODE:    tx.data_o = {4'b0010, code_word};
      default: tx.data_o = '0;
    endcase
  end
  assign debug = {state, q_count, q_full, q_empty, error, ack, tx.src_rdy_o, tx.dst_rdy_i,
                  {(22-QDEPTH_LOG2){1'b0}}};
endmodule

// File: tb/tb_vita_tx_async_msg.sv
// tb_vita_tx_async_msg: vector table, corner sequences and random traffic against a word-queue model
module tb_vita_tx_async_msg;
`ifdef VITA_TX_ASYNC_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  typedef struct {
    bit e, a, en;
    logic [31:0] code;
    logic [63:0] t;
    int npkt;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, set_stb = 1'b0, error = 1'b0, ack = 1'b0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0, error_code = '0;
  logic [63:0] vita_time = '0;
  logic [15:0] dropped_count;
  logic [31:0] debug;
  vita_tx_async_msg_if tx();
  vita_tx_async_msg #(.BASE(0), .QDEPTH_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .vita_time(vita_time), .error(error), .ack(ack),
    .error_code(error_code), .tx(tx.master), .dropped_count(dropped_count), .debug(debug)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_pkt = 0;
  logic [35:0] exp_q[$];
  logic [3:0] mseq = '0;
  logic [31:0] sid_m = '0;
  bit en_m = 1'b0;
  vec_t vt[6];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // expected packet straight from the word layout of the async message format
  task automatic expect_pkt(input logic [31:0] c, input logic [63:0] t, input bit loss);
    exp_q.push_back({4'b0001, 4'h5, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, mseq, 16'd6});
    exp_q.push_back({4'b0000, sid_m});
    exp_q.push_back({4'b0000, t[63:32]});
    exp_q.push_back(36'h0);
    exp_q.push_back({4'b0000, t[31:0]});
    exp_q.push_back({4'b0010, c[31:16], c[15] | loss, c[14:0]});
    mseq++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sr(input int a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = 8'(a);
    set_data = d;
    tick();
    set_stb = 1'b0;
  endtask
  task automatic pulse(input bit e, input bit a, input logic [31:0] c, input logic [63:0] t);
    error = e;
    ack = a;
    error_code = c;
    vita_time = t;
    tick();
    error = 1'b0;
    ack = 1'b0;
  endtask
  task automatic send(input bit e, input bit a, input logic [31:0] c, input logic [63:0] t);
    if (en_m && (e || a)) expect_pkt(c, t, 1'b0);
    pulse(e, a, c, t);
  endtask
  task automatic drain();
    tx.dst_rdy_i = 1'b1;
    for (int i = 0; i < 3000 && (exp_q.size() > 0 || tx.src_rdy_o); i++) tick();
    if (exp_q.size() > 0 || tx.src_rdy_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
    repeat (4) tick();
  endtask
  // every transfer must match the model; a stalled word must already be the next expected one
  always @(negedge clk)
    if (reset_n && !clear) begin
      if (tx.src_rdy_o && tx.dst_rdy_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got %0h expected no word", tx.data_o);
        end else begin
          chk("word", 64'(tx.data_o), 64'(exp_q.pop_front()));
          if (tx.data_o[33]) n_pkt++;
        end
      end else if (tx.src_rdy_o && exp_q.size() > 0) chk("stall_hold", 64'(tx.data_o), 64'(exp_q[0]));
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int p;
    logic [31:0] c;
    logic [63:0] t;
    vt[0] = '{e: 1, a: 0, en: 1, code: 32'h0001_0004, t: 64'h0000_0001_0000_0002, npkt: 1};
    vt[1] = '{e: 0, a: 1, en: 1, code: 32'h0002_0001, t: 64'h1234_5678_9ABC_DEF0, npkt: 1};
    vt[2] = '{e: 1, a: 1, en: 1, code: 32'h0003_8002, t: 64'hFFFF_FFFF_FFFF_FFFF, npkt: 1};
    vt[3] = '{e: 1, a: 0, en: 0, code: 32'h0004_0008, t: 64'h0000_0002_0000_0003, npkt: 0};
    vt[4] = '{e: 1, a: 1, en: 0, code: 32'h0005_0010, t: 64'h0000_0003_0000_0004, npkt: 0};
    vt[5] = '{e: 0, a: 1, en: 1, code: 32'hFFFF_FFFF, t: 64'h0, npkt: 1};
    tx.dst_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src_rdy", 64'(tx.src_rdy_o), 0);
    chk("rst_data", 64'(tx.data_o), 0);
    chk("rst_dropped", 64'(dropped_count), 0);
    chk("rst_q_empty", 64'(debug[24]), 1);
    chk("rst_q_count", 64'(debug[28:26]), 0);
    reset_n = 1'b1;
    tick();
    sr(1, 32'h1);
    en_m = 1'b1;
    sr(0, 32'hCAFE_0001);
    sid_m = 32'hCAFE_0001;
    // single ack: header appears two cycles after the capture edge
    send(1'b0, 1'b1, 32'h0007_0001, 64'h0000_0010_0000_0ABC);
    @(negedge clk);
    chk("lat_n1_rdy", 64'(tx.src_rdy_o), 0);
    @(negedge clk);
    chk("lat_n2_rdy", 64'(tx.src_rdy_o), 1);
    chk("lat_n2_hdr", 64'(tx.data_o), 64'h1_50D0_0006);
    drain();
    chk("single_npkt", 64'(n_pkt), 1);
    // same message under random backpressure
    expect_pkt(32'h0007_0001, 64'h0000_0010_0000_0ABC, 1'b0);
    pulse(1'b0, 1'b1, 32'h0007_0001, 64'h0000_0010_0000_0ABC);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      tx.dst_rdy_i = 1'($urandom % 2);
      tick();
    end
    drain();
    chk("bp_npkt", 64'(n_pkt), 2);
    for (int i = 0; i < 6; i++) begin
      if (vt[i].en != en_m) begin
        sr(1, {31'd0, vt[i].en});
        en_m = vt[i].en;
      end
      p = n_pkt;
      send(vt[i].e, vt[i].a, vt[i].code, vt[i].t);
      drain();
      chk("vec_npkt", 64'(n_pkt - p), 64'(vt[i].npkt));
      chk("vec_dropped", 64'(dropped_count), 0);
    end
    // overflow: one staged, four queued, the sixth event lost
    tx.dst_rdy_i = 1'b0;
    p = n_pkt;
    for (int i = 0; i < 6; i++) begin
      c = 32'h00A0_0000 + 32'(i);
      t = 64'h0000_0100_0000_0000 + 64'(i);
      if (i < 5) expect_pkt(c, t, DROP_EN && i == 0);
      pulse(1'b1, 1'b0, c, t);
    end
    chk("ovf_q_count", 64'(debug[28:26]), 4);
    chk("ovf_q_full", 64'(debug[25]), 1);
    chk("ovf_dropped", 64'(dropped_count), DROP_EN ? 64'd1 : 64'd0);
    chk("ovf_src_rdy", 64'(tx.src_rdy_o), 1);
    drain();
    chk("ovf_npkt", 64'(n_pkt - p), 5);
    sr(2, 32'h1);
    tick();
    chk("drop_clr", 64'(dropped_count), 0);
    // 17 messages after a flush: sequence field 0..15 then wraps to 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mseq = '0;
    p = n_pkt;
    for (int i = 0; i < 17; i++) begin
      send(1'b0, 1'b1, 32'h0100_0000 + 32'(i), {32'(i), 32'($urandom)});
      drain();
    end
    chk("seq_npkt", 64'(n_pkt - p), 17);
    // random traffic, at most four messages outstanding so nothing is dropped
    p = n_pkt;
    for (int i = 0; i < 1500; i++) begin
      tx.dst_rdy_i = 1'($urandom % 2);
      if ((exp_q.size() + 5) / 6 < 4 && $urandom % 4 == 0) begin
        c = $urandom;
        t = {$urandom, $urandom};
        case ($urandom_range(1, 3))
          1: send(1'b1, 1'b0, c, t);
          2: send(1'b0, 1'b1, c, t);
          default: send(1'b1, 1'b1, c, t);
        endcase
      end else tick();
    end
    drain();
    chk("rand_dropped", 64'(dropped_count), 0);
    // async reset in the middle of FRACH aborts the packet
    tx.dst_rdy_i = 1'b0;
    send(1'b1, 1'b0, 32'h0BAD_0005, 64'h0000_0005_0000_0007);
    tick();
    tx.dst_rdy_i = 1'b1;
    repeat (3) tick();
    tx.dst_rdy_i = 1'b0;
    @(negedge clk);
    chk("frach_rdy", 64'(tx.src_rdy_o), 1);
    chk("frach_word", 64'(tx.data_o), 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rdy", 64'(tx.src_rdy_o), 0);
    chk("async_rst_data", 64'(tx.data_o), 0);
    exp_q.delete();
    mseq = '0;
    en_m = 1'b0;
    sid_m = '0;
    tick();
    reset_n = 1'b1;
    tx.dst_rdy_i = 1'b1;
    tick();
    sr(1, 32'h1);
    en_m = 1'b1;
    p = n_pkt;
    send(1'b0, 1'b1, 32'h0009_0003, 64'h0000_0020_0000_0040);
    @(negedge clk);
    chk("post_rst_n1", 64'(tx.src_rdy_o), 0);
    @(negedge clk);
    chk("post_rst_hdr", 64'(tx.data_o), 64'h1_50D0_0006);
    drain();
    chk("post_rst_npkt", 64'(n_pkt - p), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
